// File: rtl/ws2812_bin_display_if.sv
// Dominant-bin result from the max-bin finder plus the LED strip status lines.
interface ws2812_bin_display_if #(
  parameter int unsigned SAMPLES = 16
);
  localparam int unsigned IW = $clog2(SAMPLES);

  logic [IW-1:0] index_holder;
  logic          done;
  logic          led_dout;
  logic          busy;
  logic          frame_pending;

  modport master (
    output index_holder,
    output done,
    input  led_dout,
    input  busy,
    input  frame_pending
  );

  modport slave (
    input  index_holder,
    input  done,
    output led_dout,
    output busy,
    output frame_pending
  );
endinterface

// File: rtl/ws2812_bin_display.sv
// Displays the dominant FFT bin as a coloured bar on a WS2812-style LED strip.
// Optional macro HALF_BRIGHT_EN halves the transmitted red and blue values.
module ws2812_bin_display #(
  parameter int unsigned SAMPLES      = 16,
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned TBIT         = 63,
  parameter int unsigned RESET_CYCLES = 2600
) (
  input logic                clk,
  input logic                reset,
  ws2812_bin_display_if.slave bus
);

  localparam int unsigned L    = $clog2(SAMPLES);
  localparam int unsigned N    = $clog2(NUM_LEDS);
  localparam int unsigned LW   = (N > 0) ? N : 1;
  localparam int unsigned CMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

  state_t        state, state_n;
  logic          prev_done;
  logic [L-1:0]  active_idx, active_idx_n;
  logic [L-1:0]  pend_idx, pend_idx_n;
  logic          frame_pending, frame_pending_n;
  logic [23:0]   word, word_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [LW-1:0] led_cnt, led_cnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          led_dout, led_dout_n;
  logic          busy, busy_n;

  logic          done_rise;
  logic [7:0]    red, blue, red_tx, blue_tx;
  logic [LW-1:0] top_led;
  logic [23:0]   led_word;

  function automatic logic [CW-1:0] high_time(input logic b);
    return b ? CW'(T1H - 1) : CW'(T0H - 1);
  endfunction

  function automatic logic [CW-1:0] low_time(input logic b);
    return b ? CW'(TBIT - T1H - 1) : CW'(TBIT - T0H - 1);
  endfunction

  assign done_rise = bus.done & ~prev_done;

  // Bin index to bar length and GRB colour for the LED currently being loaded.
  always_comb begin
    red     = 8'(active_idx) << (8 - L);
    blue    = 8'hFF - red;
`ifdef HALF_BRIGHT_EN
    red_tx  = red >> 1;
    blue_tx = blue >> 1;
`else
    red_tx  = red;
    blue_tx = blue;
`endif
    top_led  = LW'(active_idx >> (L - N));
    led_word = (led_cnt <= top_led) ? {8'h00, red_tx, blue_tx} : 24'h000000;
  end

  // Next-state, pending capture and serialiser datapath.
  always_comb begin
    state_n         = state;
    active_idx_n    = active_idx;
    pend_idx_n      = pend_idx;
    frame_pending_n = frame_pending;
    word_n          = word;
    bit_cnt_n       = bit_cnt;
    led_cnt_n       = led_cnt;
    cnt_n           = cnt;

    // Edges arriving mid-frame queue up; only the newest survives.
    if (done_rise && state != IDLE) begin
      pend_idx_n      = bus.index_holder;
      frame_pending_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (done_rise) begin
          active_idx_n = bus.index_holder;
          led_cnt_n    = '0;
          state_n      = LOAD;
        end
      end
      LOAD: begin
        word_n    = led_word;
        bit_cnt_n = 5'd23;
        cnt_n     = high_time(led_word[23]);
        state_n   = HIGH;
      end
      HIGH: begin
        if (cnt == '0) begin
          cnt_n   = low_time(word[23]);
          state_n = LOW;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          if (bit_cnt != 5'd0) begin
            bit_cnt_n = bit_cnt - 5'd1;
            word_n    = {word[22:0], 1'b0};
            cnt_n     = high_time(word[22]);
            state_n   = HIGH;
          end else if (led_cnt != LW'(NUM_LEDS - 1)) begin
            led_cnt_n = led_cnt + LW'(1);
            state_n   = LOAD;
          end else begin
            cnt_n   = CW'(RESET_CYCLES - 1);
            state_n = LATCH;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          // An edge on the final latch cycle is newer than any queued index.
          if (done_rise) begin
            active_idx_n    = bus.index_holder;
            frame_pending_n = 1'b0;
            led_cnt_n       = '0;
            state_n         = LOAD;
          end else if (frame_pending) begin
            active_idx_n    = pend_idx;
            frame_pending_n = 1'b0;
            led_cnt_n       = '0;
            state_n         = LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    led_dout_n = (state_n == HIGH);
    busy_n     = (state_n != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prev_done     <= 1'b0;
      active_idx    <= '0;
      pend_idx      <= '0;
      frame_pending <= 1'b0;
      word          <= '0;
      bit_cnt       <= '0;
      led_cnt       <= '0;
      cnt           <= '0;
      led_dout      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      prev_done     <= bus.done;
      active_idx    <= active_idx_n;
      pend_idx      <= pend_idx_n;
      frame_pending <= frame_pending_n;
      word          <= word_n;
      bit_cnt       <= bit_cnt_n;
      led_cnt       <= led_cnt_n;
      cnt           <= cnt_n;
      led_dout      <= led_dout_n;
      busy          <= busy_n;
    end
  end

  assign bus.led_dout      = led_dout;
  assign bus.busy          = busy;
  assign bus.frame_pending = frame_pending;

endmodule

// File: tb/tb_ws2812_bin_display.sv
// Scoreboard bench for ws2812_bin_display: decodes the strip waveform into bits.
module tb_ws2812_bin_display;

  localparam int unsigned SAMPLES  = 16;
  localparam int unsigned NUM_LEDS = 8;
  localparam int FRAME_BUSY = 192 * 6 + 8 + 10;

  logic clk = 1'b0;
  logic reset;

  ws2812_bin_display_if #(.SAMPLES(SAMPLES)) bus ();

  ws2812_bin_display #(
    .SAMPLES(SAMPLES), .NUM_LEDS(NUM_LEDS), .T0H(2), .T1H(4), .TBIT(6), .RESET_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int obs_q[$];
  int mon_hi = 0;
  int busy_total = 0;

  // Decode each high pulse into a bit: 2 cycles -> 0, 4 cycles -> 1, else 9.
  always @(negedge clk) begin
    if (reset) begin
      mon_hi = 0;
    end else if (bus.led_dout) begin
      mon_hi++;
    end else if (mon_hi != 0) begin
      obs_q.push_back(mon_hi == 4 ? 1 : (mon_hi == 2 ? 0 : 9));
      mon_hi = 0;
    end
    if (bus.busy) busy_total++;
  end

  function automatic logic [23:0] exp_word(input int idx, input int k);
    int lit;
    logic [7:0] r, b;
    lit = (idx >> 1) + 1;
    r = 8'(idx << 4);
    b = 8'hFF - r;
`ifdef HALF_BRIGHT_EN
    r = r >> 1;
    b = b >> 1;
`endif
    return (k < lit) ? {8'h00, r, b} : 24'h000000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int idx);
    logic [23:0] w;
    for (int k = 0; k < int'(NUM_LEDS); k++) begin
      w = exp_word(idx, k);
      for (int b = 23; b >= 0; b--) exp_q.push_back(int'(w[b]));
    end
  endtask

  task automatic pulse_done(input int idx);
    bus.index_holder = 4'(idx);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.frame_pending !== 1'b0 || bus.led_dout !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: busy=%b pending=%b led=%b after %0d cycles, required 0/0/0",
               name, bus.busy, bus.frame_pending, bus.led_dout, n);
    end
  endtask

  task automatic check_frame(input string name);
    int e, o, pos;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s bits: got %0d bits, required %0d", name, obs_q.size(), exp_q.size());
    end else begin
      pos = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s bit %0d: got %0d, required %0d", name, pos, o, e);
          break;
        end
        pos++;
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_busy(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s busy cycles: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.done = 1'b1;
    bus.index_holder = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_pending !== 1'b0) begin
        fails++;
        $display("FAIL reset cycle %0d: led=%b busy=%b pending=%b, required 0/0/0",
                 i, bus.led_dout, bus.busy, bus.frame_pending);
      end
    end
    bus.done = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idx0();
    int n = 0;
    int b0 = busy_total;
    push_frame(0);
    bus.index_holder = 4'd0;
    bus.done = 1'b1;
    while (bus.led_dout !== 1'b1 && n < 10) begin
      tick();
      bus.done = 1'b0;
      n++;
    end
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL latency: led_dout rose after %0d edges, required 2", n);
    end
    wait_idle(3000, "idx0");
    check_frame("idx0");
    check_busy("idx0", busy_total - b0, FRAME_BUSY);
  endtask

  task automatic test_frame(input int idx, input string name);
    int b0 = busy_total;
    push_frame(idx);
    pulse_done(idx);
    wait_idle(3000, name);
    check_frame(name);
    check_busy(name, busy_total - b0, FRAME_BUSY);
  endtask

  task automatic test_pending();
    int b0 = busy_total;
    push_frame(5);
    push_frame(12);
    pulse_done(5);
    repeat (100) tick();
    pulse_done(3);
    @(negedge clk);
    tests++;
    if (bus.frame_pending !== 1'b1) begin
      fails++;
      $display("FAIL pending set: frame_pending=%b, required 1", bus.frame_pending);
    end
    repeat (100) tick();
    pulse_done(12);
    wait_idle(5000, "pending");
    check_frame("pending");
    check_busy("pending", busy_total - b0, 2 * FRAME_BUSY);
  endtask

  task automatic test_latch_edge();
    int b0 = busy_total;
    push_frame(2);
    push_frame(14);
    pulse_done(2);
    repeat (FRAME_BUSY - 1) @(posedge clk);
    #1;
    pulse_done(14);
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1 || bus.frame_pending !== 1'b0) begin
      fails++;
      $display("FAIL latch edge: busy=%b pending=%b, required 1/0", bus.busy, bus.frame_pending);
    end
    wait_idle(5000, "latch_edge");
    check_frame("latch_edge");
    check_busy("latch_edge", busy_total - b0, 2 * FRAME_BUSY);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int b0;
    pulse_done(15);
    repeat (50) tick();
    pulse_done(7);
    @(negedge clk);
    tests++;
    if (bus.frame_pending !== 1'b1) begin
      fails++;
      $display("FAIL midreset pending: frame_pending=%b, required 1", bus.frame_pending);
    end
    while (obs_q.size() < 50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_pending !== 1'b0) begin
      fails++;
      $display("FAIL midreset outputs: led=%b busy=%b pending=%b, required 0/0/0",
               bus.led_dout, bus.busy, bus.frame_pending);
    end
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    b0 = busy_total;
    push_frame(9);
    pulse_done(9);
    wait_idle(3000, "after_reset");
    check_frame("after_reset");
    repeat (20) tick();
    check_busy("after_reset", busy_total - b0, FRAME_BUSY);
  endtask

  initial begin
    reset = 1'b1;
    bus.done = 1'b0;
    bus.index_holder = '0;
    test_reset();
    test_idx0();
    test_frame(15, "idx15");
    test_frame(9, "idx9");
    test_pending();
    test_latch_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
